// File: rtl/ask_symbol_gen.sv
//==============================================================================
// ask_symbol_gen -- PRBS-driven 2/4-ASK symbol mapper with zero-stuffed upsampling
// Revision 1.0
//==============================================================================
`default_nettype none

module ask_symbol_gen #(
  parameter int          WIDTH = 18,
  parameter int          SPS   = 4,
  parameter int          AMP   = 32768,
  parameter logic [14:0] SEED  = 15'h7FFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [1:0]              mode,
  output logic signed [WIDTH-1:0] x_out,
  output logic                    out_valid,
  output logic                    sym_strobe,
  output logic [1:0]              sym_out
);

  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(SPS - 1);

  localparam logic [1:0] MODE_ASK4    = 2'd0;
  localparam logic [1:0] MODE_IMPULSE = 2'd1;
  localparam logic [1:0] MODE_CONST   = 2'd2;
  localparam logic [1:0] MODE_ASK2    = 2'd3;

  localparam logic signed [WIDTH-1:0] LVL_P1 = WIDTH'(AMP);
  localparam logic signed [WIDTH-1:0] LVL_P3 = WIDTH'(3 * AMP);
  localparam logic signed [WIDTH-1:0] LVL_M1 = -LVL_P1;
  localparam logic signed [WIDTH-1:0] LVL_M3 = -LVL_P3;

  if (SPS < 1 || SPS > 16) begin : g_chk_sps
    $error("ask_symbol_gen: SPS must be within 1..16");
  end
  if ((64'(3) * 64'(AMP)) > ((64'(1) << (WIDTH - 1)) - 64'(1))) begin : g_chk_amp
    $error("ask_symbol_gen: 3*AMP does not fit in WIDTH-bit signed");
  end
  if (SEED == 15'h0000) begin : g_chk_seed
    $error("ask_symbol_gen: SEED must be nonzero");
  end

  function automatic logic [14:0] lfsr_step(input logic [14:0] v);
    return {v[13:0], v[14] ^ v[13]};
  endfunction

  logic [PW-1:0]           phase, phase_nxt;
  logic [14:0]             lfsr, lfsr_nxt, lfsr_adv;
  logic                    imp_done, imp_nxt;
  logic                    boundary;
  logic [1:0]              sym;
  logic signed [WIDTH-1:0] sample;
  logic [1:0]              sym_nxt;

  assign boundary = en && (phase == '0);
  assign sym      = lfsr[14:13];
  // A zero state can never leave itself, so it is forced back onto the sequence.
  assign lfsr_adv = (lfsr == 15'h0000) ? 15'h0001 : lfsr_step(lfsr_step(lfsr));

  always_comb begin
    phase_nxt = phase;
    lfsr_nxt  = (lfsr == 15'h0000) ? 15'h0001 : lfsr;
    imp_nxt   = imp_done;
    sample    = '0;
    sym_nxt   = sym_out;
    if (en) begin
      phase_nxt = (phase == LAST_PHASE) ? '0 : phase + 1'b1;
    end
    if (boundary) begin
      imp_nxt = 1'b0;
      case (mode)
        MODE_ASK4: begin
          lfsr_nxt = lfsr_adv;
          sym_nxt  = sym;
          case (sym)
            2'b00:   sample = LVL_M3;
            2'b01:   sample = LVL_M1;
            2'b11:   sample = LVL_P1;
            default: sample = LVL_P3;
          endcase
        end
        MODE_IMPULSE: begin
          imp_nxt = 1'b1;
          sample  = imp_done ? '0 : LVL_P3;
          sym_nxt = imp_done ? 2'b00 : 2'b10;
        end
        MODE_CONST: begin
          sample  = LVL_P3;
          sym_nxt = 2'b10;
        end
        default: begin
          lfsr_nxt = lfsr_adv;
          sym_nxt  = {sym[1], sym[1]};
          sample   = sym[1] ? LVL_P3 : LVL_M3;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      lfsr       <= SEED;
      imp_done   <= 1'b0;
      x_out      <= '0;
      out_valid  <= 1'b0;
      sym_strobe <= 1'b0;
      sym_out    <= 2'b00;
    end else begin
      phase      <= phase_nxt;
      lfsr       <= lfsr_nxt;
      imp_done   <= imp_nxt;
      out_valid  <= en;
      sym_strobe <= boundary;
      if (en) begin
        x_out   <= sample;
        sym_out <= sym_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ask_symbol_gen.sv
//==============================================================================
// tb_ask_symbol_gen -- directed vector table plus model scoreboard for SPS 1/4/16
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_ask_symbol_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic signed [17:0] x1, x4, x16;
  logic        v1, v4, v16, s1, s4, s16;
  logic [1:0]  y1, y4, y16;

  ask_symbol_gen #(.SPS(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .x_out(x1), .out_valid(v1), .sym_strobe(s1), .sym_out(y1));
  ask_symbol_gen dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .x_out(x4), .out_valid(v4), .sym_strobe(s4), .sym_out(y4));
  ask_symbol_gen #(.SPS(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .x_out(x16), .out_valid(v16), .sym_strobe(s16), .sym_out(y16));

  int n_vec = 0;
  int n_err = 0;

  // Reference model, one slot per instance (SPS 1, 4, 16).
  int          sps_of [3] = '{1, 4, 16};
  int          m_phase[3];
  int          m_x    [3];
  logic [14:0] m_lfsr [3];
  bit          m_imp  [3];
  bit          m_v    [3];
  bit          m_s    [3];
  bit          sb_on = 1'b0;

  function automatic logic [14:0] st(input logic [14:0] v);
    return {v[13:0], v[14] ^ v[13]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_phase[k] = 0; m_lfsr[k] = 15'h7FFF; m_imp[k] = 1'b0;
      m_x[k] = 0; m_v[k] = 1'b0; m_s[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    logic [14:0] l;
    logic [1:0]  sy;
    l = m_lfsr[k];
    sy = l[14:13];
    m_v[k] = en;
    m_s[k] = 1'b0;
    if (en) begin
      if (m_phase[k] == 0) begin
        m_s[k] = 1'b1;
        case (mode)
          2'd0: begin
            m_x[k] = (sy == 2'b00) ? -98304 : (sy == 2'b01) ? -32768 :
                     (sy == 2'b11) ? 32768 : 98304;
            m_lfsr[k] = st(st(l));
          end
          2'd1: begin
            m_x[k] = m_imp[k] ? 0 : 98304;
            m_imp[k] = 1'b1;
          end
          2'd2: m_x[k] = 98304;
          default: begin
            m_x[k] = sy[1] ? 98304 : -98304;
            m_lfsr[k] = st(st(l));
          end
        endcase
        if (mode != 2'd1) m_imp[k] = 1'b0;
      end else begin
        m_x[k] = 0;
      end
      m_phase[k] = (m_phase[k] + 1) % sps_of[k];
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    int ax; bit av, as;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
    if (sb_on && !reset) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       begin ax = int'(x1);  av = v1;  as = s1;  end
          1:       begin ax = int'(x4);  av = v4;  as = s4;  end
          default: begin ax = int'(x16); av = v16; as = s16; end
        endcase
        n_vec++;
        if (ax != m_x[k] || av != m_v[k] || as != m_s[k]) begin
          n_err++;
          $display("FAIL scoreboard sps=%0d t=%0t: x/valid/strobe got %0d/%0b/%0b, expected %0d/%0b/%0b",
                   sps_of[k], $time, ax, av, as, m_x[k], m_v[k], m_s[k]);
        end
      end
    end
  endtask

  typedef struct {
    bit         en;
    logic [1:0] mode;
    int         x;
    bit         v;
    bit         s;
    bit         cs;
    logic [1:0] sym;
  } vec_t;

  vec_t tbl[$];

  task automatic put(input bit e, input logic [1:0] m, input int x, input bit v,
                     input bit s, input bit cs, input logic [1:0] sy);
    vec_t r;
    r.en = e; r.mode = m; r.x = x; r.v = v; r.s = s; r.cs = cs; r.sym = sy;
    tbl.push_back(r);
  endtask

  // One full SPS=4 symbol with en held high: a level on phase 0, then three zeros.
  task automatic put4(input logic [1:0] m, input int x0, input bit cs, input logic [1:0] sy);
    put(1'b1, m, x0, 1'b1, 1'b1, cs, sy);
    for (int j = 0; j < 3; j++) put(1'b1, m, 0, 1'b1, 1'b0, cs, sy);
  endtask

  int  pos_cnt, ref_cnt;
  bit  lfsr_ok;

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'd0;
    model_reset();

    // LFSR from 7FFF yields symbols 11,11,11 for the first boundaries.
    put4(2'd0, 32768, 1'b1, 2'b11);
    put4(2'd0, 32768, 1'b1, 2'b11);
    put(1, 2'd2, 98304, 1, 1, 1, 2'b10);
    put(0, 2'd2, 98304, 0, 0, 1, 2'b10);
    put(1, 2'd2, 0,     1, 0, 1, 2'b10);
    put(0, 2'd2, 0,     0, 0, 1, 2'b10);
    put(1, 2'd2, 0,     1, 0, 1, 2'b10);
    put(0, 2'd2, 0,     0, 0, 1, 2'b10);
    put(1, 2'd2, 0,     1, 0, 1, 2'b10);
    put(0, 2'd2, 0,     0, 0, 1, 2'b10);
    put4(2'd1, 98304, 1'b0, 2'b00);
    put4(2'd1, 0,     1'b0, 2'b00);
    put4(2'd3, 98304, 1'b1, 2'b11);
    put(1, 2'd0, 32768, 1, 1, 1, 2'b11);
    put(1, 2'd0, 0,     1, 0, 1, 2'b11);
    put(0, 2'd0, 0,     0, 0, 1, 2'b11);
    put(0, 2'd0, 0,     0, 0, 1, 2'b11);
    put(1, 2'd0, 0,     1, 0, 1, 2'b11);
    put(1, 2'd2, 0,     1, 0, 1, 2'b11);
    put(1, 2'd2, 98304, 1, 1, 1, 2'b10);
    put(1, 2'd0, 0,     1, 0, 1, 2'b10);
    put(1, 2'd0, 0,     1, 0, 1, 2'b10);
    put(1, 2'd0, 0,     1, 0, 1, 2'b10);
    put(1, 2'd0, 32768, 1, 1, 1, 2'b11);

    tick(); tick();
    chk("reset x_out", int'(x4), 0);
    chk("reset out_valid", int'(v4), 0);
    chk("reset sym_strobe", int'(s4), 0);
    chk("reset sym_out", int'(y4), 0);
    reset = 1'b0;
    sb_on = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en; mode = tbl[i].mode;
      tick();
      chk($sformatf("tbl[%0d] x_out", i), int'(x4), tbl[i].x);
      chk($sformatf("tbl[%0d] out_valid", i), int'(v4), int'(tbl[i].v));
      chk($sformatf("tbl[%0d] sym_strobe", i), int'(s4), int'(tbl[i].s));
      if (tbl[i].cs) chk($sformatf("tbl[%0d] sym_out", i), int'(y4), int'(tbl[i].sym));
    end

    // Impulse: one +3A then silence; re-arms only after a boundary outside mode 1.
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 2'd1; en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      chk($sformatf("impulse[%0d] x_out", i), int'(x4), (i == 0) ? 98304 : 0);
    end
    tick(); tick();
    mode = 2'd2;
    tick(); tick();
    chk("mode2 mid-symbol x_out", int'(x4), 0);
    tick();
    chk("mode2 boundary x_out", int'(x4), 98304);
    mode = 2'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rearm[%0d] x_out", i), int'(x4), (i == 3) ? 98304 : 0);
      chk($sformatf("rearm[%0d] sym_strobe", i), int'(s4), (i % 4 == 3) ? 1 : 0);
    end

    // Asynchronous reset pulse between edges at phase 2.
    mode = 2'd0; en = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("async reset x_out", int'(x4), 0);
    chk("async reset out_valid", int'(v4), 0);
    chk("async reset sym_out", int'(y4), 0);
    chk("async reset sps16 out_valid", int'(v16), 0);
    #1 reset = 1'b0;
    model_reset();
    tick();
    chk("post-reset x_out", int'(x4), 32768);
    chk("post-reset sym_strobe", int'(s4), 1);

    // 2-ASK at SPS=1: every sample is +/-3A.
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 2'd3; en = 1'b1;
    pos_cnt = 0; ref_cnt = 0; lfsr_ok = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (m_lfsr[0][14]) ref_cnt++;
      tick();
      if (x1 == 18'sd98304) pos_cnt++;
      chk($sformatf("ask2[%0d] level", i), int'(x1 == 18'sd98304 || x1 == -18'sd98304), 1);
      if (dut1.lfsr == 15'h0000) lfsr_ok = 1'b0;
    end
    chk("ask2 +3A count", pos_cnt, ref_cnt);
    chk("ask2 lfsr nonzero", int'(lfsr_ok), 1);

    // Random enables and mode changes against the model, all three SPS values.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ask_symbol_gen.md
ASK_SYMBOL_GEN -- requirements
Module: ask_symbol_gen

Interface
REQ-001 Parameter WIDTH, default 18: output sample width, signed 1s17 format at default.
REQ-002 Parameter SPS, default 4: samples per symbol (upsampling factor); legal range 1..16.
REQ-003 Parameter AMP, default 32768: inner level magnitude A; the elaboration check SHALL fail if 3*AMP > 2^(WIDTH-1)-1.
REQ-004 Parameter SEED, default 15'h7FFF: LFSR reset value; the elaboration check SHALL fail if it is zero.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  sample-rate enable; one output sample is produced per clk with en=1.
REQ-008 mode  input  2  0=PRBS 4-ASK, 1=impulse, 2=constant +3A, 3=PRBS 2-ASK (+/-3A).
REQ-009 x_out  output  WIDTH  signed sample, registered.
REQ-010 out_valid  output  1  high for the cycle after a sample is loaded (registered en).
REQ-011 sym_strobe  output  1  high with out_valid when x_out carries a symbol (phase 0).
REQ-012 sym_out  output  2  symbol bits used for the current x_out, registered.

Function
REQ-013 The phase counter SHALL count 0..SPS-1 on each en=1 edge, wrap to 0, and hold when en=0.
REQ-014 A symbol boundary SHALL be an en=1 edge with phase=0; only boundaries SHALL consume LFSR bits, sample mode, or produce nonzero x_out.
REQ-015 The LFSR SHALL be 15 bits, x^15+x^14+1: the step is lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}.
REQ-016 At each boundary, sym = {lfsr[14], lfsr[13]} from the current LFSR value, then the LFSR SHALL advance two steps within that same edge.
REQ-017 If the LFSR value is ever 0, it SHALL load 15'h0001 instead of stepping (lock-up guard).
REQ-018 The mode 0 Gray map SHALL be: 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A.
REQ-019 Mode 3 SHALL use sym[1] only: 1 -> +3A, 0 -> -3A; sym_out = {sym[1], sym[1]}; the LFSR still advances two steps.
REQ-020 Mode 2 SHALL output +3A at every boundary, with sym_out=2'b10; the LFSR SHALL hold.
REQ-021 Mode 1 SHALL output +3A at the first boundary after entering mode 1 (or after reset while in mode 1), then 0 at all later boundaries until mode leaves 1; the LFSR SHALL hold.
REQ-022 Non-boundary en=1 edges SHALL load x_out=0, sym_strobe=0, and hold sym_out (zero-stuffing).
REQ-023 mode SHALL be sampled only at boundaries; a change mid-symbol SHALL take effect at the next phase 0.
REQ-024 When en=0: x_out and sym_out hold; out_valid=0; sym_strobe=0; phase and LFSR hold.
REQ-025 Latency SHALL be one clk: the sample chosen on an en=1 edge appears on x_out after that edge, with out_valid=1.
REQ-026 SPS=1 SHALL make every en=1 edge a boundary, with no zero samples.
REQ-027 All level arithmetic SHALL be in WIDTH-bit signed without overflow; -3A SHALL be exactly the two's complement of 3A.

Reset
REQ-028 On reset: x_out=0, out_valid=0, sym_strobe=0, sym_out=0, phase=0, lfsr=SEED, impulse-done flag cleared; asynchronous, takes effect independent of clk.
REQ-029 Reset asserted mid-symbol SHALL abandon the symbol; the first en=1 edge after release SHALL be a boundary.

Verification
REQ-030 Default parameters, mode 0, en=1 continuously after reset: x_out = 32768,0,0,0,32768,0,0,0 (symbols 11,11 from SEED 7FFF -> 7FFC); sym_strobe on the 1st and 5th samples.
REQ-031 Mode 1, en=1: x_out = 98304 followed by only zeros for at least 40 samples; switch to mode 2 mid-symbol, then back to mode 1 -> 98304 reappears exactly once, at a phase 0.
REQ-032 en toggled 1,0,1,0 in mode 2: out_valid follows en one cycle later; x_out holds through en=0; x_out sequence 98304,0,0,0 spans 8 clks.
REQ-033 Reset pulse asserted at phase 2, between clk edges: outputs go to 0 before the next edge; after release, the first sample is a boundary with lfsr=SEED (x_out=32768 in mode 0).
REQ-034 Mode 3 with SPS=1, 2000 samples: every x_out is +/-98304; the +98304 count equals the lfsr[14]=1 count in a reference model; the LFSR never reaches 0.
REQ-035 A scoreboard SHALL compare x_out against a bit-true model for SPS in {1,4,16} and all modes, with random en and random mode changes.
